// File: rtl/poly_eval.sv
// poly_eval: sequential Horner polynomial evaluator, one multiply or add per cycle.
// Coefficients c[0..DEGREE] are written through a simple write port while idle.
// Optional feature: define POLY_EVAL_OVF_EN to add the sticky overflow output `ovf`.
module poly_eval #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEGREE = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [WIDTH-1:0]               x,
    input  logic                           coef_we,
    input  logic [$clog2(DEGREE+1)-1:0]    coef_addr,
    input  logic [WIDTH-1:0]               coef_data,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH-1:0]               resultado
`ifdef POLY_EVAL_OVF_EN
    ,
    output logic                           ovf
`endif
);

    localparam int unsigned   AW        = $clog2(DEGREE + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEGREE);
    localparam logic [AW-1:0] FIRST_IDX = AW'(DEGREE - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  temp_q, temp_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  resultado_q, resultado_d;
    logic [WIDTH-1:0]  coef_q [DEGREE+1];
    logic [WIDTH-1:0]  coef_d [DEGREE+1];

    // A write landing in the same cycle as an accepted start must not be seen
    // by that evaluation; the overwritten value is parked here and substituted
    // when the evaluation reaches that index.
    logic              hold_valid_q, hold_valid_d;
    logic [AW-1:0]     hold_addr_q, hold_addr_d;
    logic [WIDTH-1:0]  hold_data_q, hold_data_d;

    logic              wr_ok;
    logic [WIDTH-1:0]  coef_sel;
    logic [WIDTH-1:0]  prod_w;
    logic [WIDTH-1:0]  sum_w;

`ifdef POLY_EVAL_OVF_EN
    logic              ovf_q, ovf_d;
    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH:0]    sum_full;
    logic              prod_ovf;
    logic              sum_ovf;
`endif

    assign wr_ok    = coef_we && (state_q == IDLE) && (coef_addr <= LAST_ADDR);
    assign coef_sel = (hold_valid_q && (hold_addr_q == idx_q)) ? hold_data_q : coef_q[idx_q];

`ifdef POLY_EVAL_OVF_EN
    assign prod_full = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
    assign sum_full  = {1'b0, temp_q} + {1'b0, coef_sel};
    assign prod_w    = prod_full[WIDTH-1:0];
    assign sum_w     = sum_full[WIDTH-1:0];
    assign prod_ovf  = |prod_full[2*WIDTH-1:WIDTH];
    assign sum_ovf   = sum_full[WIDTH];
    assign ovf       = ovf_q;
`else
    assign prod_w    = acc_q * x_q;
    assign sum_w     = temp_q + coef_sel;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign resultado = resultado_q;

    // Next-state and datapath updates for the IDLE/MUL/ADD/DONE sequence
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        acc_d        = acc_q;
        temp_d       = temp_q;
        idx_d        = idx_q;
        resultado_d  = resultado_q;
        coef_d       = coef_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
`ifdef POLY_EVAL_OVF_EN
        ovf_d        = ovf_q;
`endif

        if (wr_ok) begin
            coef_d[coef_addr] = coef_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d          = x;
                    acc_d        = coef_q[DEGREE];
                    idx_d        = FIRST_IDX;
                    hold_valid_d = wr_ok;
                    hold_addr_d  = coef_addr;
                    if (wr_ok) begin
                        hold_data_d = coef_q[coef_addr];
                    end
`ifdef POLY_EVAL_OVF_EN
                    ovf_d        = 1'b0;
`endif
                    state_d      = MUL;
                end
            end
            MUL: begin
                temp_d  = prod_w;
`ifdef POLY_EVAL_OVF_EN
                ovf_d   = ovf_q | prod_ovf;
`endif
                state_d = ADD;
            end
            ADD: begin
                acc_d = sum_w;
`ifdef POLY_EVAL_OVF_EN
                ovf_d = ovf_q | sum_ovf;
`endif
                if (idx_q == '0) begin
                    resultado_d = sum_w;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and coefficient registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            acc_q        <= '0;
            temp_q       <= '0;
            idx_q        <= '0;
            resultado_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            for (int unsigned i = 0; i <= DEGREE; i++) begin
                coef_q[i] <= '0;
            end
`ifdef POLY_EVAL_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            acc_q        <= acc_d;
            temp_q       <= temp_d;
            idx_q        <= idx_d;
            resultado_q  <= resultado_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            coef_q       <= coef_d;
`ifdef POLY_EVAL_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_poly_eval.sv
// Testbench for poly_eval (WIDTH=16, DEGREE=2): table vectors, corner sequences
// and random polynomials against a power-sum reference model.
module tb_poly_eval;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
    logic        busy;
    logic        done;
    logic [15:0] resultado;
`ifdef POLY_EVAL_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mc [3];
    logic [15:0] last_res;

    typedef struct {
        logic [15:0] c2;
        logic [15:0] c1;
        logic [15:0] c0;
        logic [15:0] xv;
        logic [15:0] res;
        logic        ovf;
        string       name;
    } vec_t;

    vec_t tbl [6];

    poly_eval #(
        .WIDTH (16),
        .DEGREE(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .busy     (busy),
        .done     (done),
        .resultado(resultado)
`ifdef POLY_EVAL_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Sum of c[i]*x^i modulo 2^16
    function automatic logic [15:0] ref_poly(input logic [15:0] xv);
        longint unsigned s;
        longint unsigned p;
        s = 0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            s = (s + longint'(mc[i]) * p) % 65536;
            p = (p * longint'(xv)) % 65536;
        end
        return s[15:0];
    endfunction

    // Overflow: any Horner product or sum above 0xFFFF
    function automatic logic ref_ovf(input logic [15:0] xv);
        longint unsigned a;
        longint unsigned t;
        logic ov;
        ov = 1'b0;
        a  = longint'(mc[2]);
        for (int i = 1; i >= 0; i--) begin
            t = a * longint'(xv);
            if (t > 65535) ov = 1'b1;
            t = (t % 65536) + longint'(mc[i]);
            if (t > 65535) ov = 1'b1;
            a = t % 65536;
        end
        return ov;
    endfunction

    task automatic write_coef(input int a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
        if (a <= 2) mc[a] = d;
    endtask

    // mode 0: plain; 1: write c0=0x00FF while busy; 2: change x while busy;
    // 3: write c0=0x0100 in the same cycle as start
    task automatic run_eval(input logic [15:0] xv, input logic [15:0] er, input logic eo,
                            input int mode, input string nm);
        int cyc;
        bit seen;
        x     = xv;
        start = 1'b1;
        if (mode == 3) begin
            coef_we   = 1'b1;
            coef_addr = 2'd0;
            coef_data = 16'h0100;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start   = 1'b0;
                coef_we = 1'b0;
                chk({nm, "_busy"}, 32'(busy), 32'd1);
                chk({nm, "_held"}, 32'(resultado), 32'(last_res));
            end
            if (mode == 1 && cyc == 2) begin
                coef_we   = 1'b1;
                coef_addr = 2'd0;
                coef_data = 16'h00FF;
            end
            if (mode == 1 && cyc == 3) coef_we = 1'b0;
            if (mode == 2 && cyc == 2) x = 16'h7777;
            if (done) seen = 1'b1;
        end
        chk({nm, "_latency"}, 32'(cyc - 1), 32'd4);
        chk({nm, "_result"}, 32'(resultado), 32'(er));
        chk({nm, "_busy_at_done"}, 32'(busy), 32'd1);
`ifdef POLY_EVAL_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo !== 1'bx) begin end
`endif
        last_res = er;
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        int d1;
        int d2;
        logic [15:0] rx;

        tbl[0] = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0045, 1'b0, "basic"};
        tbl[1] = '{16'h0001, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1'b1, "wrap"};
        tbl[2] = '{16'h1234, 16'hBEEF, 16'h0007, 16'h0000, 16'h0007, 1'b0, "x_zero"};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFD, 1'b1, "all_ones"};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0, "zero_poly"};
        tbl[5] = '{16'h0003, 16'h0000, 16'h0001, 16'h0010, 16'h0301, 1'b0, "sparse"};

        rst       = 1'b1;
        start     = 1'b0;
        x         = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        for (int i = 0; i < 3; i++) mc[i] = '0;
        last_res  = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(resultado), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // First start after reset with all-zero coefficients
        run_eval(16'h0005, 16'h0000, 1'b0, 0, "post_reset");

        for (int i = 0; i < 6; i++) begin
            write_coef(2, tbl[i].c2);
            write_coef(1, tbl[i].c1);
            write_coef(0, tbl[i].c0);
            run_eval(tbl[i].xv, tbl[i].res, tbl[i].ovf, 0, tbl[i].name);
        end

        // Busy-time write is dropped; next evaluation uses the old c0
        write_coef(2, 16'h0001);
        write_coef(1, 16'h0001);
        write_coef(0, 16'h0002);
        run_eval(16'h0003, 16'h000E, 1'b0, 1, "busy_write");
        run_eval(16'h0003, 16'h000E, 1'b0, 0, "busy_write_after");

        // Out-of-range address is ignored
        write_coef(3, 16'hAAAA);
        run_eval(16'h0003, 16'h000E, 1'b0, 0, "bad_addr");

        // x changed during evaluation
        run_eval(16'h0003, 16'h000E, 1'b0, 2, "x_change");

        // Write and start in the same cycle: old c0 used, write still commits
        write_coef(1, 16'h0002);
        write_coef(0, 16'h0003);
        run_eval(16'h0002, 16'h000B, 1'b0, 3, "same_cycle_write");
        mc[0] = 16'h0100;
        run_eval(16'h0002, ref_poly(16'h0002), ref_ovf(16'h0002), 0, "same_cycle_after");

        // start held high for 10 cycles: one done, then a fresh evaluation after IDLE
        rx    = 16'h0007;
        x     = rx;
        start = 1'b1;
        ndone = 0;
        d1    = 0;
        d2    = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (cyc == 10) start = 1'b0;
            if (cyc == 6) chk("held_start_idle_gap", 32'(busy), 32'd0);
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = cyc;
                if (ndone == 2) d2 = cyc;
            end
        end
        chk("held_start_done_count", 32'(ndone), 32'd2);
        chk("held_start_first_done", 32'(d1), 32'd5);
        chk("held_start_second_done", 32'(d2), 32'd11);
        chk("held_start_result", 32'(resultado), 32'(ref_poly(rx)));
        last_res = ref_poly(rx);

        // Single start pulse during busy is not queued
        x     = 16'h0004;
        start = 1'b1;
        ndone = 0;
        d1    = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) start = 1'b1;
            if (cyc == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = cyc;
            end
        end
        chk("no_queue_done_count", 32'(ndone), 32'd1);
        chk("no_queue_done_cycle", 32'(d1), 32'd5);
        last_res = ref_poly(16'h0004);

        // Overflowing evaluation ahead of the mid-run reset
        write_coef(2, 16'hFFFF);
        run_eval(16'h0002, ref_poly(16'h0002), ref_ovf(16'h0002), 0, "pre_reset");

        // Reset two edges into an evaluation
        x     = 16'h0003;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(resultado), 32'd0);
`ifdef POLY_EVAL_OVF_EN
        chk("abort_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        for (int i = 0; i < 3; i++) mc[i] = '0;
        last_res = '0;
        run_eval(16'h0005, 16'h0000, 1'b0, 0, "coef_cleared");

        // Random polynomials
        for (int n = 0; n < 25; n++) begin
            logic [15:0] r0;
            logic [15:0] r1;
            logic [15:0] r2;
            r2 = (n % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            r1 = 16'($urandom);
            r0 = 16'($urandom);
            rx = (n % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            write_coef(2, r2);
            write_coef(1, r1);
            write_coef(0, r0);
            run_eval(rx, ref_poly(rx), ref_ovf(rx), 0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
